usb_line_receiver: RTL and testbench
====================================

# usb_line_receiver

Full-speed USB receive path for the 48 MHz device core, sitting between the line buffers and the packet/annunciator logic. It is the receive-side partner of the device transmitter that drives tx_en/tx_j/tx_se0. It recovers the 12 Mb/s bit clock from the oversampled line, detects SYNC, decodes NRZI, removes stuffed bits, and delivers bytes with strobes, along with EOP, error and bus-reset indications.

## Interface
- USB_RST_CYCLES, 120: consecutive SE0 clocks (2.5 µs at 48 MHz) before usb_rst asserts.
- SYNC_MIN_ZEROS, 5: minimum decoded 0 bits preceding the SYNC-terminating 1.
- clk48  input  1  48 MHz clock; one clock domain; all state on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_j  input  1  line in J state (D+ high); asynchronous to clk48.
- rx_se0  input  1  both lines low; asynchronous to clk48.
- tx_en  input  1  local transmitter driving; receiver blanked.
- rx_data  output  8  received byte, LSB first on the wire; held until the next byte.
- rx_valid  output  1  one-clock strobe, rx_data new.
- rx_active  output  1  high from SYNC detect to EOP or abort.
- rx_eop  output  1  one-clock strobe, clean end of packet.
- rx_error  output  1  one-clock strobe, stuff error or misaligned EOP.
- usb_rst  output  1  level, high while SE0 persists ≥ USB_RST_CYCLES.

## Operation
- Input conditioning: rx_j and rx_se0 pass through 2-flop synchronizers. Line state is {se0, j}: SE0, J or K.
- DPLL: a 2-bit phase counter advances each clock. Any change of synchronized line state forces phase to 0. The sample strobe fires at phase 2. One strobe per 4 clocks with no edges, giving 12 Mb/s.
- NRZI decode at each strobe:
  - Bit = 1 if the sampled J/K equals the previous sample, else 0.
  - Previous sample resets to J.
- States:
  - IDLE → HUNT: on a K sample.
  - HUNT: counts consecutive decoded 0s, saturating at 7. A 1 with count ≥ SYNC_MIN_ZEROS → ACTIVE. A 1 with count less than that → IDLE.
  - ACTIVE: shifts unstuffed bits into rx_data from the MSB side; after 8 bits, pulses rx_valid.
  - ABORT: waits for a J sample after SE0, or 8 consecutive J samples, then → IDLE.
- Unstuffing:
  - The ones counter counts consecutive decoded 1s, including the SYNC-terminating 1.
  - After six 1s, the next bit is discarded if 0.
  - If that bit is 1: pulse rx_error, drop rx_active, go to ABORT.
- EOP: an SE0 sample in ACTIVE ends the packet.
  - Bit count 0 mod 8: pulse rx_eop on the first following J sample, then → IDLE.
  - Otherwise: pulse rx_error immediately, then → ABORT.
  - In both cases rx_active falls in the same cycle as the strobe.
- Blanking: while tx_en is high, the state is forced to IDLE, no strobes are generated, and the NRZI reference is set to J.
- usb_rst: a counter of consecutive synchronized-SE0 clocks, saturating. Asserts when the count reaches USB_RST_CYCLES and deasserts on the first non-SE0 clock. It is independent of the state machine and of tx_en.

## Timing
- Reset values: rx_data 0x00; rx_valid, rx_active, rx_eop, rx_error and usb_rst all 0; state IDLE; phase 0.
- Line-to-decision latency: 2 clocks of synchronization plus 2 clocks to the phase-2 sample.
- rx_active rises 1 clock after the strobe that completes SYNC.
- rx_valid is registered 1 clock after the strobe delivering the 8th unstuffed bit.
- rx_valid and rx_eop are never high in the same cycle.
- Jitter tolerance: bit periods of 3–5 clocks are decoded correctly because the phase realigns on every edge.
- Simultaneous events:
  - tx_en rising mid-packet: rx_active drops next clock, with no rx_error or rx_eop.
  - rst asserted mid-packet: all outputs clear asynchronously.
  - usb_rst and an EOP-path rx_error may coincide.
- Runs of more than 6 identical samples without an edge are decoded using the free-running phase.

## Structure
- Package usb_pkg holds:
  - the state enum (IDLE, HUNT, ACTIVE, ABORT);
  - the line-state encoding (J, K, SE0);
  - the stuff limit constant 6;
  - the default reset-cycle constant.
- Sub-module usb_rx_dpll holds the synchronizers, edge detect and phase counter. It outputs a sample strobe plus the sampled j/se0.

## Test plan
- Packet decode: SYNC, then PID 0x2D, then 0x00 and 0x10, then 2-bit SE0 EOP, then J. Expect rx_valid ×3 with rx_data 0x2D, 0x00, 0x10, followed by one rx_eop and no rx_error.
- Bit stuffing: payload 0xFF 0xFF with correct stuffed zeros. Expect rx_data 0xFF twice and clean EOP.
- Stuff error: seven consecutive 1s after SYNC. Expect an rx_error pulse, rx_active low, no further rx_valid until the next SYNC.
- Misaligned EOP: SE0 after 5 data bits. Expect rx_error, no rx_eop.
- Bus reset: SE0 held 200 clocks. Expect usb_rst high at clock 120 + 2 of the SE0, low 3 clocks after J returns.
- Jitter and blanking:
  - Bit periods alternating 3/5 clocks across a 0xA5 packet: expect correct decode.
  - tx_en high during an identical packet: expect no strobes at all.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types and constants for the full-speed USB receive path.
// Line-state encoding, receiver states and framing limits.
`timescale 1ns/1ps
package usb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HUNT,
      ACTIVE,
      ABORT
   } state_t;

   typedef enum logic [1:0] {
      LS_K   = 2'b00,
      LS_J   = 2'b01,
      LS_SE0 = 2'b10
   } line_t;

   localparam logic [2:0] STUFF_LIMIT    = 3'd6;
   localparam int         USB_RST_DEF    = 120;
   localparam int         SYNC_ZEROS_DEF = 5;

   // SE0 dominates whatever D+ happens to read.
   function automatic line_t line_state(
      input logic se0,
      input logic j
   );
      if (se0) return LS_SE0;
      return j ? LS_J : LS_K;
   endfunction

endpackage

// File: rtl/usb_rx_dpll.sv
// Bit-clock recovery for the 12 Mb/s line oversampled at 48 MHz.
// Synchronizes the line, realigns phase on edges, strobes mid-bit.
`timescale 1ns/1ps
module usb_rx_dpll
   import usb_pkg::*;
(
   input  logic clk48,
   input  logic rst,
   input  logic rx_j,
   input  logic rx_se0,
   input  logic tx_en,
   output logic stb,
   output logic sj,
   output logic sse0,
   output logic se0_lvl
);

   logic       j1, j2;
   logic       s1, s2;
   line_t      ls_cur;
   line_t      ls_q;
   logic [1:0] phase;

   assign ls_cur = line_state(s2, j2);

   // Two-flop synchronizers; idle line reads as J out of reset.
   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         j1 <= 1'b1;
         j2 <= 1'b1;
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         j1 <= rx_j;
         j2 <= j1;
         s1 <= rx_se0;
         s2 <= s1;
      end
   end

   // Phase restarts on any line-state change, else free-runs mod 4.
   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         ls_q  <= LS_J;
         phase <= 2'd0;
      end else begin
         ls_q  <= ls_cur;
         phase <= (ls_cur != ls_q) ? 2'd0 : phase + 2'd1;
      end
   end

   assign stb     = (phase == 2'd2) && !tx_en;
   assign sj      = (ls_q == LS_J);
   assign sse0    = (ls_q == LS_SE0);
   assign se0_lvl = s2;

endmodule

// File: rtl/usb_line_receiver.sv
// Full-speed USB receiver: SYNC hunt, NRZI decode, unstuffing,
// byte assembly, EOP/error framing and bus-reset detection.
`timescale 1ns/1ps
module usb_line_receiver
   import usb_pkg::*;
#(
   parameter int USB_RST_CYCLES = USB_RST_DEF,
   parameter int SYNC_MIN_ZEROS = SYNC_ZEROS_DEF
) (
   input  logic       clk48,
   input  logic       rst,
   input  logic       rx_j,
   input  logic       rx_se0,
   input  logic       tx_en,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_active,
   output logic       rx_eop,
   output logic       rx_error,
   output logic       usb_rst
);

   localparam int            RW   = $clog2(USB_RST_CYCLES + 1);
   localparam logic [RW-1:0] RMAX = RW'(USB_RST_CYCLES);
   localparam logic [RW-1:0] RPRE = RW'(USB_RST_CYCLES - 1);
   localparam logic [2:0]    SMZ  = 3'(SYNC_MIN_ZEROS);

   logic          stb;
   logic          sj;
   logic          sse0;
   logic          se0_lvl;
   state_t        state;
   logic          prev_j;
   logic          dbit;
   logic [2:0]    zcnt;
   logic [2:0]    ones;
   logic [2:0]    bitcnt;
   logic [2:0]    jcnt;
   logic [7:0]    shreg;
   logic          seen_se0;
   logic          eop_pend;
   logic [RW-1:0] se0_cnt;

   usb_rx_dpll u_dpll (
      .clk48   (clk48),
      .rst     (rst),
      .rx_j    (rx_j),
      .rx_se0  (rx_se0),
      .tx_en   (tx_en),
      .stb     (stb),
      .sj      (sj),
      .sse0    (sse0),
      .se0_lvl (se0_lvl)
   );

   assign dbit = (sj == prev_j);

   // Packet framing state machine, advanced on each sample strobe.
   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         prev_j    <= 1'b1;
         zcnt      <= '0;
         ones      <= '0;
         bitcnt    <= '0;
         jcnt      <= '0;
         shreg     <= '0;
         seen_se0  <= 1'b0;
         eop_pend  <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_active <= 1'b0;
         rx_eop    <= 1'b0;
         rx_error  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_eop   <= 1'b0;
         rx_error <= 1'b0;
         if (tx_en) begin
            state     <= IDLE;
            prev_j    <= 1'b1;
            rx_active <= 1'b0;
            seen_se0  <= 1'b0;
            eop_pend  <= 1'b0;
         end else if (stb) begin
            if (!sse0) prev_j <= sj;
            unique case (state)
               IDLE: begin
                  if (!sse0 && !sj) begin
                     state <= HUNT;
                     zcnt  <= 3'd1;
                  end
               end
               HUNT: begin
                  if (sse0) begin
                     state <= IDLE;
                  end else if (!dbit) begin
                     if (zcnt != 3'd7) zcnt <= zcnt + 3'd1;
                  end else if (zcnt >= SMZ) begin
                     state     <= ACTIVE;
                     rx_active <= 1'b1;
                     ones      <= 3'd1;
                     bitcnt    <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
               ACTIVE: begin
                  if (sse0) begin
                     state     <= ABORT;
                     rx_active <= 1'b0;
                     seen_se0  <= 1'b1;
                     jcnt      <= '0;
                     eop_pend  <= (bitcnt == 3'd0);
                     rx_error  <= (bitcnt != 3'd0);
                  end else if (ones == STUFF_LIMIT) begin
                     if (!dbit) begin
                        ones <= '0;
                     end else begin
                        state     <= ABORT;
                        rx_active <= 1'b0;
                        rx_error  <= 1'b1;
                        seen_se0  <= 1'b0;
                        eop_pend  <= 1'b0;
                        jcnt      <= '0;
                     end
                  end else begin
                     shreg  <= {dbit, shreg[7:1]};
                     ones   <= dbit ? ones + 3'd1 : 3'd0;
                     bitcnt <= bitcnt + 3'd1;
                     if (bitcnt == 3'd7) begin
                        rx_data  <= {dbit, shreg[7:1]};
                        rx_valid <= 1'b1;
                     end
                  end
               end
               ABORT: begin
                  if (sse0) begin
                     seen_se0 <= 1'b1;
                     jcnt     <= '0;
                  end else if (sj) begin
                     if (seen_se0 || jcnt == 3'd7) begin
                        state    <= IDLE;
                        rx_eop   <= eop_pend;
                        eop_pend <= 1'b0;
                        seen_se0 <= 1'b0;
                     end else begin
                        jcnt <= jcnt + 3'd1;
                     end
                  end else begin
                     jcnt     <= '0;
                     seen_se0 <= 1'b0;
                     eop_pend <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   // Bus reset: saturating run length of synchronized SE0 clocks.
   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         se0_cnt <= '0;
         usb_rst <= 1'b0;
      end else if (!se0_lvl) begin
         se0_cnt <= '0;
         usb_rst <= 1'b0;
      end else begin
         if (se0_cnt != RMAX) se0_cnt <= se0_cnt + 1'b1;
         usb_rst <= (se0_cnt == RMAX) || (se0_cnt == RPRE);
      end
   end

endmodule

// File: tb/tb_usb_line_receiver.sv
// Bench for usb_line_receiver: packets are built from bytes by an
// NRZI/stuffing encoder and decoded events compared to the bytes.
`timescale 1ns/1ps
module tb_usb_line_receiver;

   logic       clk48 = 1'b0;
   logic       rst = 1'b1;
   logic       rx_j = 1'b1;
   logic       rx_se0 = 1'b0;
   logic       tx_en = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_active;
   logic       rx_eop;
   logic       rx_error;
   logic       usb_rst;

   int         tests = 0;
   int         fails = 0;
   int         ev_q[$];
   int         exp_q[$];
   bit         act_seen;
   logic [1:0] sq[$];
   bit         lvl;
   int         ones_e;

   usb_line_receiver dut (
      .clk48     (clk48),
      .rst       (rst),
      .rx_j      (rx_j),
      .rx_se0    (rx_se0),
      .tx_en     (tx_en),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_active (rx_active),
      .rx_eop    (rx_eop),
      .rx_error  (rx_error),
      .usb_rst   (usb_rst)
   );

   always #10 clk48 = ~clk48;

   // Event log: 1xx byte, 200 eop, 40a error (a = rx_active), 800 clash
   always @(negedge clk48) begin
      if (rx_valid && rx_eop) ev_q.push_back(32'h800);
      if (rx_valid) ev_q.push_back(32'h100 | int'(rx_data));
      if (rx_eop) ev_q.push_back(32'h200);
      if (rx_error) ev_q.push_back(32'h400 | int'(rx_active));
      if (rx_active) act_seen = 1'b1;
   end

   function automatic string evstr(input int q[$]);
      string s = "";
      foreach (q[i]) s = {s, $sformatf("%03h ", q[i])};
      return s;
   endfunction

   task automatic idle(input int n);
      rx_se0 = 1'b0;
      rx_j   = 1'b1;
      repeat (n) @(negedge clk48);
   endtask

   // NRZI: a 0 toggles the line; six 1s force a stuffed 0.
   task automatic enc_bit(input bit b, input bit stuff);
      if (!b) lvl = !lvl;
      sq.push_back({1'b0, lvl});
      ones_e = b ? ones_e + 1 : 0;
      if (stuff && ones_e == 6) begin
         lvl = !lvl;
         sq.push_back({1'b0, lvl});
         ones_e = 0;
      end
   endtask

   task automatic add_sync();
      lvl    = 1'b1;
      ones_e = 0;
      for (int i = 0; i < 7; i++) enc_bit(1'b0, 1'b1);
      enc_bit(1'b1, 1'b1);
   endtask

   task automatic add_byte(input logic [7:0] b, input int n,
                           input bit stuff);
      for (int i = 0; i < n; i++) enc_bit(b[i], stuff);
   endtask

   task automatic add_eop();
      sq.push_back(2'b10);
      sq.push_back(2'b10);
      sq.push_back(2'b01);
      lvl = 1'b1;
   endtask

   // Jittered mode alternates 3- and 5-clock bit periods.
   task automatic play(input bit jit, input int tail);
      int d;
      d = ($urandom_range(0, 1) == 1) ? 3 : 5;
      foreach (sq[i]) begin
         rx_se0 = sq[i][1];
         rx_j   = sq[i][0];
         repeat (jit ? d : 4) @(negedge clk48);
         d = 8 - d;
      end
      sq.delete();
      idle(tail);
   endtask

   task automatic send_pkt(input logic [7:0] b[$], input bit jit);
      ev_q.delete();
      exp_q.delete();
      act_seen = 1'b0;
      add_sync();
      foreach (b[i]) begin
         add_byte(b[i], 8, 1'b1);
         exp_q.push_back(32'h100 | int'(b[i]));
      end
      add_eop();
      exp_q.push_back(32'h200);
      play(jit, 50);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      tests++;
      if ({rx_data, rx_valid, rx_active, rx_eop, rx_error,
           usb_rst} !== 13'h0) begin
         fails++;
         $display("FAIL reset_hold got %h %b%b%b%b%b want 00 00000",
                  rx_data, rx_valid, rx_active, rx_eop, rx_error,
                  usb_rst);
      end
      rst = 1'b0;
      idle(10);
      tests++;
      if ({rx_data, rx_valid, rx_active, rx_eop, rx_error,
           usb_rst} !== 13'h0) begin
         fails++;
         $display("FAIL reset_idle got %h %b%b%b%b%b want 00 00000",
                  rx_data, rx_valid, rx_active, rx_eop, rx_error,
                  usb_rst);
      end
   endtask

   task automatic test_packet();
      logic [7:0] b[$];
      b = '{8'h2D, 8'h00, 8'h10};
      send_pkt(b, 1'b0);
      tests++;
      if (evstr(ev_q) != evstr(exp_q)) begin
         fails++;
         $display("FAIL packet got %s want %s",
                  evstr(ev_q), evstr(exp_q));
      end
   endtask

   task automatic test_stuffing();
      logic [7:0] b[$];
      b = '{8'hFF, 8'hFF};
      send_pkt(b, 1'b0);
      tests++;
      if (evstr(ev_q) != evstr(exp_q)) begin
         fails++;
         $display("FAIL stuffing got %s want %s",
                  evstr(ev_q), evstr(exp_q));
      end
   endtask

   task automatic test_random();
      logic [7:0] b[$];
      bit jit;
      for (int p = 0; p < 6; p++) begin
         b.delete();
         repeat ($urandom_range(1, 4)) b.push_back(8'($urandom));
         jit = ($urandom_range(0, 1) == 1);
         send_pkt(b, jit);
         tests++;
         if (evstr(ev_q) != evstr(exp_q)) begin
            fails++;
            $display("FAIL random%0d jit=%0d got %s want %s",
                     p, jit, evstr(ev_q), evstr(exp_q));
         end
      end
   endtask

   task automatic test_jitter();
      logic [7:0] b[$];
      b = '{8'hA5};
      send_pkt(b, 1'b1);
      tests++;
      if (evstr(ev_q) != evstr(exp_q)) begin
         fails++;
         $display("FAIL jitter got %s want %s",
                  evstr(ev_q), evstr(exp_q));
      end
   endtask

   task automatic test_stuff_error();
      ev_q.delete();
      exp_q = '{32'h400, 32'h1C3, 32'h200};
      add_sync();
      add_byte(8'hFF, 7, 1'b0);
      add_byte(8'h55, 8, 1'b0);
      add_eop();
      play(1'b0, 50);
      add_sync();
      add_byte(8'hC3, 8, 1'b1);
      add_eop();
      play(1'b0, 50);
      tests++;
      if (evstr(ev_q) != evstr(exp_q)) begin
         fails++;
         $display("FAIL stuff_error got %s want %s",
                  evstr(ev_q), evstr(exp_q));
      end
   endtask

   task automatic test_misaligned_eop();
      ev_q.delete();
      exp_q = '{32'h400};
      add_sync();
      add_byte(8'h0D, 5, 1'b1);
      add_eop();
      play(1'b0, 50);
      tests++;
      if (evstr(ev_q) != evstr(exp_q)) begin
         fails++;
         $display("FAIL misaligned_eop got %s want %s",
                  evstr(ev_q), evstr(exp_q));
      end
   endtask

   task automatic test_bus_reset();
      rx_se0 = 1'b1;
      rx_j   = 1'b0;
      repeat (121) @(negedge clk48);
      tests++;
      if (usb_rst !== 1'b0) begin
         fails++;
         $display("FAIL usb_rst_clk121 got %b want 0", usb_rst);
      end
      @(negedge clk48);
      tests++;
      if (usb_rst !== 1'b1) begin
         fails++;
         $display("FAIL usb_rst_clk122 got %b want 1", usb_rst);
      end
      repeat (78) @(negedge clk48);
      rx_se0 = 1'b0;
      rx_j   = 1'b1;
      repeat (2) @(negedge clk48);
      tests++;
      if (usb_rst !== 1'b1) begin
         fails++;
         $display("FAIL usb_rst_j2 got %b want 1", usb_rst);
      end
      @(negedge clk48);
      tests++;
      if (usb_rst !== 1'b0) begin
         fails++;
         $display("FAIL usb_rst_j3 got %b want 0", usb_rst);
      end
      idle(40);
   endtask

   task automatic test_blanking();
      logic [7:0] b[$];
      b = '{8'hA5};
      tx_en = 1'b1;
      send_pkt(b, 1'b1);
      tx_en = 1'b0;
      idle(20);
      exp_q.delete();
      tests++;
      if (evstr(ev_q) != evstr(exp_q)) begin
         fails++;
         $display("FAIL blanking_events got %s want none",
                  evstr(ev_q));
      end
      tests++;
      if (act_seen !== 1'b0) begin
         fails++;
         $display("FAIL blanking_active got %b want 0", act_seen);
      end
   endtask

   task automatic test_tx_mid_packet();
      ev_q.delete();
      exp_q = '{32'h169};
      add_sync();
      add_byte(8'h69, 8, 1'b1);
      add_byte(8'h0F, 3, 1'b1);
      play(1'b0, 0);
      tests++;
      if (rx_active !== 1'b1) begin
         fails++;
         $display("FAIL txmid_active_before got %b want 1",
                  rx_active);
      end
      tx_en = 1'b1;
      @(negedge clk48);
      tests++;
      if (rx_active !== 1'b0) begin
         fails++;
         $display("FAIL txmid_active_after got %b want 0",
                  rx_active);
      end
      add_byte(8'h01, 5, 1'b1);
      add_eop();
      play(1'b0, 50);
      tx_en = 1'b0;
      idle(20);
      tests++;
      if (evstr(ev_q) != evstr(exp_q)) begin
         fails++;
         $display("FAIL txmid_events got %s want %s",
                  evstr(ev_q), evstr(exp_q));
      end
   endtask

   task automatic test_async_reset();
      ev_q.delete();
      add_sync();
      add_byte(8'h3C, 8, 1'b1);
      add_byte(8'h00, 2, 1'b1);
      play(1'b0, 0);
      tests++;
      if (rx_data !== 8'h3C || rx_active !== 1'b1) begin
         fails++;
         $display("FAIL arst_before got %h/%b want 3c/1",
                  rx_data, rx_active);
      end
      #3 rst = 1'b1;
      #1;
      tests++;
      if ({rx_data, rx_valid, rx_active, rx_eop, rx_error,
           usb_rst} !== 13'h0) begin
         fails++;
         $display("FAIL arst_clear got %h %b%b%b%b%b want 00 00000",
                  rx_data, rx_valid, rx_active, rx_eop, rx_error,
                  usb_rst);
      end
      @(negedge clk48);
      rst = 1'b0;
      idle(60);
   endtask

   initial begin
      test_reset();
      test_packet();
      test_stuffing();
      test_random();
      test_jitter();
      test_stuff_error();
      test_misaligned_eop();
      test_bus_reset();
      test_blanking();
      test_tx_mid_packet();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
